// File: rtl/wb_commit_arbiter.sv
// Writeback/commit stage: per-channel FIFOs, one grant per cycle, registered
// regfile write and commit record with MMIO difftest skip and retire counter.
module wb_commit_arbiter #(
    parameter int          N_CH       = 2,
    parameter int          DEPTH      = 2,
    parameter int          XLEN       = 64,
    parameter int          PC_W       = 64,
    parameter int          ARB_MODE   = 0,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_3000_0000,
    parameter logic [63:0] MMIO_LIMIT = 64'h0000_0000_4070_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 commit_stall,
    input  logic [N_CH-1:0]      ch_valid,
    output logic [N_CH-1:0]      ch_ready,
    input  logic [N_CH*5-1:0]    ch_rd,
    input  logic [N_CH-1:0]      ch_need_to_wb,
    input  logic [N_CH*XLEN-1:0] ch_result,
    input  logic [N_CH-1:0]      ch_is_load,
    input  logic [N_CH-1:0]      ch_is_store,
    input  logic [N_CH*XLEN-1:0] ch_ls_address,
    input  logic [N_CH*PC_W-1:0] ch_pc,
    input  logic [N_CH*32-1:0]   ch_instr,
    output logic                 regfile_write_valid,
    output logic [4:0]           regfile_write_rd,
    output logic [XLEN-1:0]      regfile_write_data,
    output logic                 commit_valid,
    output logic [PC_W-1:0]      commit_pc,
    output logic [31:0]          commit_instr,
    output logic                 commit_rfwen,
    output logic                 commit_skip,
    output logic [2:0]           commit_src,
    output logic [63:0]          retire_count
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]      N_CH4    = 4'(N_CH);
    localparam logic [XLEN-1:0] MMIO_LO  = XLEN'(MMIO_BASE);
    localparam logic [XLEN-1:0] MMIO_HI  = XLEN'(MMIO_LIMIT);
    localparam int              ENTRY_W  = 5 + 1 + XLEN + 1 + 1 + XLEN + PC_W + 32;

    logic [N_CH-1:0]    nonempty;
    logic [N_CH-1:0]    push;
    logic [N_CH-1:0]    pop;
    logic [ENTRY_W-1:0] head_entry [N_CH];

    logic               grant_any;
    logic               grant_valid;
    logic [2:0]         grant_idx;
    logic [2:0]         rr_ptr_reg;
    logic [2:0]         rr_ptr_next;
    logic [3:0]         rr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_fifo
            logic [ENTRY_W-1:0] mem [DEPTH];
            logic [ENTRY_W-1:0] in_entry;
            logic [AW-1:0]      wr_ptr_reg;
            logic [AW-1:0]      rd_ptr_reg;
            logic [AW:0]        count_reg;

            assign in_entry = {ch_rd[gi*5 +: 5], ch_need_to_wb[gi],
                               ch_result[gi*XLEN +: XLEN], ch_is_load[gi], ch_is_store[gi],
                               ch_ls_address[gi*XLEN +: XLEN], ch_pc[gi*PC_W +: PC_W],
                               ch_instr[gi*32 +: 32]};

            // Ready looks only at the registered count, so a full FIFO refuses
            // a push even in the cycle it is being popped.
            assign ch_ready[gi]   = ~reset & (count_reg != FULL_CNT);
            assign nonempty[gi]   = (count_reg != '0);
            assign push[gi]       = ch_valid[gi] & ch_ready[gi] & ~flush;
            assign pop[gi]        = grant_valid & (grant_idx == 3'(gi));
            assign head_entry[gi] = mem[rd_ptr_reg];

            always_ff @(posedge clock) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_entry;
                end
            end

            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = '0;
        if (ARB_MODE == 0) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!grant_any && nonempty[c]) begin
                    grant_any = 1'b1;
                    grant_idx = 3'(c);
                end
            end
        end else begin
            // Walk N_CH positions starting at rr_ptr, wrapping at N_CH.
            for (int k = 0; k < N_CH; k++) begin
                rr_idx = {1'b0, rr_ptr_reg} + 4'(k);
                if (rr_idx >= N_CH4) begin
                    rr_idx = rr_idx - N_CH4;
                end
                for (int c = 0; c < N_CH; c++) begin
                    if (!grant_any && nonempty[c] && (rr_idx == 4'(c))) begin
                        grant_any = 1'b1;
                        grant_idx = 3'(c);
                    end
                end
            end
        end
    end

    assign grant_valid = grant_any & ~flush & ~commit_stall;
    assign rr_ptr_next = (grant_idx == 3'(N_CH - 1)) ? 3'd0 : grant_idx + 3'd1;

    logic [ENTRY_W-1:0] sel_entry;
    logic [4:0]         sel_rd;
    logic               sel_need_to_wb;
    logic [XLEN-1:0]    sel_result;
    logic               sel_is_load;
    logic               sel_is_store;
    logic [XLEN-1:0]    sel_addr;
    logic [PC_W-1:0]    sel_pc;
    logic [31:0]        sel_instr;
    logic               sel_mmio;

    always_comb begin
        sel_entry = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_idx == 3'(c)) begin
                sel_entry = head_entry[c];
            end
        end
    end

    assign {sel_rd, sel_need_to_wb, sel_result, sel_is_load, sel_is_store,
            sel_addr, sel_pc, sel_instr} = sel_entry;

    assign sel_mmio = (sel_is_load | sel_is_store) &
                      (sel_addr >= MMIO_LO) & (sel_addr <= MMIO_HI);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rr_ptr_reg <= '0;
        end else if (grant_valid) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regfile_write_valid <= 1'b0;
            regfile_write_rd    <= '0;
            regfile_write_data  <= '0;
            commit_valid        <= 1'b0;
            commit_pc           <= '0;
            commit_instr        <= '0;
            commit_skip         <= 1'b0;
            commit_src          <= '0;
            retire_count        <= '0;
        end else if (grant_valid) begin
            // MMIO loads are not written back; difftest replays them from the ref.
            regfile_write_valid <= sel_need_to_wb & ~(sel_mmio & sel_is_load);
            regfile_write_rd    <= sel_rd;
            regfile_write_data  <= sel_result;
            commit_valid        <= 1'b1;
            commit_pc           <= sel_pc;
            commit_instr        <= sel_instr;
            commit_skip         <= sel_mmio;
            commit_src          <= grant_idx;
            retire_count        <= retire_count + 64'd1;
        end else begin
            regfile_write_valid <= 1'b0;
            commit_valid        <= 1'b0;
        end
    end

    assign commit_rfwen = regfile_write_valid;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench: dut_a is 2-channel fixed priority, dut_b is 3-channel round-robin.
module tb_wb_commit_arbiter;

    logic clock;
    logic reset;

    // dut_a: N_CH=2, ARB_MODE=0
    logic         a_flush, a_stall;
    logic [1:0]   a_valid, a_ready, a_ntw, a_ld, a_st;
    logic [9:0]   a_rd;
    logic [127:0] a_result, a_addr, a_pc;
    logic [63:0]  a_instr;
    logic         a_rfv, a_cv, a_rfwen, a_skip;
    logic [4:0]   a_rfrd;
    logic [63:0]  a_rfdata, a_cpc, a_retire;
    logic [31:0]  a_cinstr;
    logic [2:0]   a_src;

    // dut_b: N_CH=3, ARB_MODE=1
    logic         b_flush, b_stall;
    logic [2:0]   b_valid, b_ready, b_ntw, b_ld, b_st;
    logic [14:0]  b_rd;
    logic [191:0] b_result, b_addr, b_pc;
    logic [95:0]  b_instr;
    logic         b_rfv, b_cv, b_rfwen, b_skip;
    logic [4:0]   b_rfrd;
    logic [63:0]  b_rfdata, b_cpc, b_retire;
    logic [31:0]  b_cinstr;
    logic [2:0]   b_src;

    int errors = 0;
    int checks = 0;

    wb_commit_arbiter #(.N_CH(2), .DEPTH(2), .ARB_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .flush(a_flush), .commit_stall(a_stall),
        .ch_valid(a_valid), .ch_ready(a_ready), .ch_rd(a_rd), .ch_need_to_wb(a_ntw),
        .ch_result(a_result), .ch_is_load(a_ld), .ch_is_store(a_st),
        .ch_ls_address(a_addr), .ch_pc(a_pc), .ch_instr(a_instr),
        .regfile_write_valid(a_rfv), .regfile_write_rd(a_rfrd),
        .regfile_write_data(a_rfdata), .commit_valid(a_cv), .commit_pc(a_cpc),
        .commit_instr(a_cinstr), .commit_rfwen(a_rfwen), .commit_skip(a_skip),
        .commit_src(a_src), .retire_count(a_retire)
    );

    wb_commit_arbiter #(.N_CH(3), .DEPTH(2), .ARB_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .flush(b_flush), .commit_stall(b_stall),
        .ch_valid(b_valid), .ch_ready(b_ready), .ch_rd(b_rd), .ch_need_to_wb(b_ntw),
        .ch_result(b_result), .ch_is_load(b_ld), .ch_is_store(b_st),
        .ch_ls_address(b_addr), .ch_pc(b_pc), .ch_instr(b_instr),
        .regfile_write_valid(b_rfv), .regfile_write_rd(b_rfrd),
        .regfile_write_data(b_rfdata), .commit_valid(b_cv), .commit_pc(b_cpc),
        .commit_instr(b_cinstr), .commit_rfwen(b_rfwen), .commit_skip(b_skip),
        .commit_src(b_src), .retire_count(b_retire)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (a_cv) $display("dut_a commit src=%0d pc=%h rd=%0d data=%h wen=%0b skip=%0b",
                           a_src, a_cpc, a_rfrd, a_rfdata, a_rfwen, a_skip);
        if (b_cv) $display("dut_b commit src=%0d pc=%h", b_src, b_cpc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_set(input int ch, input logic v, input logic [63:0] pc, input logic [4:0] rd,
                         input logic [63:0] data, input logic ntw, input logic ld,
                         input logic st, input logic [63:0] addr);
        a_valid[ch]           = v;
        a_pc[ch*64 +: 64]     = pc;
        a_rd[ch*5 +: 5]       = rd;
        a_result[ch*64 +: 64] = data;
        a_ntw[ch]             = ntw;
        a_ld[ch]              = ld;
        a_st[ch]              = st;
        a_addr[ch*64 +: 64]   = addr;
        a_instr[ch*32 +: 32]  = pc[31:0] ^ 32'h13;
    endtask

    task automatic b_set(input int ch, input logic v, input logic [63:0] pc);
        b_valid[ch]          = v;
        b_pc[ch*64 +: 64]    = pc;
        b_instr[ch*32 +: 32] = pc[31:0];
    endtask

    task automatic a_commit(input string tag, input logic [63:0] pc, input logic [2:0] src);
        check({tag, "_valid"}, 64'(a_cv), 64'd1);
        check({tag, "_pc"}, a_cpc, pc);
        check({tag, "_src"}, 64'(a_src), 64'(src));
    endtask

    // Push one entry on ch0 and advance to the cycle where it is committed.
    task automatic a_single(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data,
                            input logic ntw, input logic ld, input logic st,
                            input logic [63:0] addr);
        a_set(0, 1'b1, pc, rd, data, ntw, ld, st, addr);
        tick();
        a_valid = '0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        a_flush = 0; a_stall = 0; a_valid = '0; a_ntw = '0; a_ld = '0; a_st = '0;
        a_rd = '0; a_result = '0; a_addr = '0; a_pc = '0; a_instr = '0;
        b_flush = 0; b_stall = 0; b_valid = '0; b_ntw = '0; b_ld = '0; b_st = '0;
        b_rd = '0; b_result = '0; b_addr = '0; b_pc = '0; b_instr = '0;

        tick();
        tick();
        check("rst_ready_a", 64'(a_ready), 64'd0);
        check("rst_ready_b", 64'(b_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_ready_a_after", 64'(a_ready), 64'h3);
        check("rst_ready_b_after", 64'(b_ready), 64'h7);
        check("rst_cv", 64'(a_cv), 64'd0);
        check("rst_rfv", 64'(a_rfv), 64'd0);
        check("rst_retire", a_retire, 64'd0);

        // Single push, two-cycle latency
        a_set(0, 1'b1, 64'h8000_0000, 5'd5, 64'h1234, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_valid = '0;
        check("t1_no_fallthru", 64'(a_cv), 64'd0);
        tick();
        a_commit("t1", 64'h8000_0000, 3'd0);
        check("t1_rfv", 64'(a_rfv), 64'd1);
        check("t1_rd", 64'(a_rfrd), 64'd5);
        check("t1_data", a_rfdata, 64'h1234);
        check("t1_instr", 64'(a_cinstr), 64'h8000_0013);
        check("t1_rfwen", 64'(a_rfwen), 64'd1);
        check("t1_retire", a_retire, 64'd1);
        tick();
        check("t1_pulse", 64'(a_cv), 64'd0);

        // Fixed-priority contention
        a_set(0, 1'b1, 64'h100, 5'd1, 64'hA0, 1'b1, 1'b0, 1'b0, 64'h0);
        a_set(1, 1'b1, 64'h200, 5'd2, 64'hB0, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_set(0, 1'b1, 64'h104, 5'd3, 64'hA4, 1'b1, 1'b0, 1'b0, 64'h0);
        a_set(1, 1'b1, 64'h204, 5'd4, 64'hB4, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_valid = '0;
        check("t2_ready_full1", 64'(a_ready), 64'h1);
        a_commit("t2_c0", 64'h100, 3'd0);
        tick();
        check("t2_ready_full1b", 64'(a_ready), 64'h1);
        a_commit("t2_c1", 64'h104, 3'd0);
        tick();
        check("t2_ready_free", 64'(a_ready), 64'h3);
        a_commit("t2_c2", 64'h200, 3'd1);
        check("t2_c2_data", a_rfdata, 64'hB0);
        tick();
        a_commit("t2_c3", 64'h204, 3'd1);
        check("t2_c3_rd", 64'(a_rfrd), 64'd4);
        tick();
        check("t2_idle", 64'(a_cv), 64'd0);
        check("t2_retire", a_retire, 64'd5);

        // MMIO classification
        a_single(64'h10, 5'd7, 64'h77, 1'b1, 1'b1, 1'b0, 64'h3000_0000);
        check("mmio_lo_cv", 64'(a_cv), 64'd1);
        check("mmio_lo_skip", 64'(a_skip), 64'd1);
        check("mmio_lo_rfv", 64'(a_rfv), 64'd0);
        check("mmio_lo_rfwen", 64'(a_rfwen), 64'd0);
        a_single(64'h14, 5'd8, 64'h88, 1'b1, 1'b1, 1'b0, 64'h4070_0001);
        check("mmio_above_skip", 64'(a_skip), 64'd0);
        check("mmio_above_rfv", 64'(a_rfv), 64'd1);
        check("mmio_above_data", a_rfdata, 64'h88);
        a_single(64'h18, 5'd0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h4070_0000);
        check("mmio_hi_store_skip", 64'(a_skip), 64'd1);
        check("mmio_hi_store_rfv", 64'(a_rfv), 64'd0);
        a_single(64'h1C, 5'd9, 64'h99, 1'b1, 1'b1, 1'b0, 64'h2FFF_FFFF);
        check("mmio_below_skip", 64'(a_skip), 64'd0);
        check("mmio_below_rfv", 64'(a_rfv), 64'd1);
        a_single(64'h20, 5'd0, 64'h55, 1'b1, 1'b0, 1'b0, 64'h3000_0010);
        check("alu_inrange_skip", 64'(a_skip), 64'd0);
        check("alu_rd0_rfv", 64'(a_rfv), 64'd1);
        check("mmio_retire", a_retire, 64'd10);
        tick();

        // Stall then flush with a same-cycle push
        a_stall = 1'b1;
        a_set(0, 1'b1, 64'h300, 5'd1, 64'h30, 1'b1, 1'b0, 1'b0, 64'h0);
        a_set(1, 1'b1, 64'h400, 5'd2, 64'h40, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_valid[0] = 1'b0;
        a_set(1, 1'b1, 64'h404, 5'd3, 64'h44, 1'b1, 1'b0, 1'b0, 64'h0);
        check("stall_cv_s1", 64'(a_cv), 64'd0);
        tick();
        a_valid = '0;
        check("stall_ready", 64'(a_ready), 64'h1);
        check("stall_cv_s2", 64'(a_cv), 64'd0);
        tick();
        check("stall_cv_s3", 64'(a_cv), 64'd0);
        tick();
        check("stall_cv_s4", 64'(a_cv), 64'd0);
        a_stall = 1'b0;
        a_flush = 1'b1;
        a_set(0, 1'b1, 64'h500, 5'd6, 64'h50, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_flush = 1'b0;
        a_valid = '0;
        check("flush_cv", 64'(a_cv), 64'd0);
        check("flush_ready", 64'(a_ready), 64'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_commit", 64'(a_cv), 64'd0);
        end
        check("flush_retire", a_retire, 64'd10);

        // Full FIFO popped with a push pending in the same cycle
        a_stall = 1'b1;
        a_set(0, 1'b1, 64'h600, 5'd10, 64'h60, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_set(0, 1'b1, 64'h604, 5'd11, 64'h64, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_stall = 1'b0;
        a_set(0, 1'b1, 64'h608, 5'd12, 64'h68, 1'b1, 1'b0, 1'b0, 64'h0);
        check("full_ready0", 64'(a_ready[0]), 64'd0);
        check("full_cv", 64'(a_cv), 64'd0);
        tick();
        check("full_ready0_after", 64'(a_ready[0]), 64'd1);
        a_commit("full_c0", 64'h600, 3'd0);
        tick();
        a_valid = '0;
        a_commit("full_c1", 64'h604, 3'd0);
        tick();
        a_commit("full_c2", 64'h608, 3'd0);
        check("full_c2_data", a_rfdata, 64'h68);
        tick();
        check("full_no_dup", 64'(a_cv), 64'd0);
        check("full_retire", a_retire, 64'd13);

        // Round-robin over three full channels
        b_stall = 1'b1;
        for (int c = 0; c < 3; c++) b_set(c, 1'b1, 64'h1000 + 64'(c) * 64'h100);
        tick();
        for (int c = 0; c < 3; c++) b_set(c, 1'b1, 64'h1004 + 64'(c) * 64'h100);
        tick();
        b_valid = '0;
        b_stall = 1'b0;
        check("rr_all_full", 64'(b_ready), 64'd0);
        tick();
        for (int j = 0; j < 6; j++) begin
            check("rr_cv", 64'(b_cv), 64'd1);
            check("rr_src", 64'(b_src), 64'(j % 3));
            check("rr_pc", b_cpc, 64'h1000 + 64'(j % 3) * 64'h100 + 64'(j / 3) * 64'd4);
            tick();
        end
        check("rr_idle", 64'(b_cv), 64'd0);
        check("rr_retire", b_retire, 64'd6);

        // Reset mid-operation drops buffered entries
        a_set(0, 1'b1, 64'h700, 5'd1, 64'h70, 1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        a_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cv", 64'(a_cv), 64'd0);
        check("mid_rst_retire", a_retire, 64'd0);
        tick();
        check("mid_rst_ready", 64'(a_ready), 64'h3);
        check("mid_rst_dropped", 64'(a_cv), 64'd0);
        tick();
        check("mid_rst_dropped2", 64'(a_cv), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_commit_arbiter.md
Name: wb_commit_arbiter

Overview:
Parametrised writeback/commit stage for the in-order backend. It accepts completed instructions from N_CH execution channels (exu, mem, later muldiv and others), buffers each channel in its own FIFO, and arbitrates one instruction per cycle. The granted instruction drives a registered regfile write and commit record, including an MMIO skip flag for difftest. It generalises the single fixed-priority exe2wb register to N channels with depth, a selectable arbitration mode, stall, flush and a retire counter.

Parameters:
N_CH, 2, number of producer channels (1..8)
DEPTH, 2, entries per channel FIFO (power of two, >=2)
XLEN, 64, result and address width
PC_W, 64, pc width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
MMIO_BASE, 64'h30000000, inclusive lower MMIO bound
MMIO_LIMIT, 64'h40700000, inclusive upper MMIO bound

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  drop all buffered entries
commit_stall  in  1  inhibit grant this cycle
ch_valid  in  N_CH  per-channel completion valid
ch_ready  out  N_CH  per-channel FIFO not full
ch_rd  in  N_CH*5  destination lreg
ch_need_to_wb  in  N_CH  writes regfile
ch_result  in  N_CH*XLEN  result or load data
ch_is_load  in  N_CH  load
ch_is_store  in  N_CH  store
ch_ls_address  in  N_CH*XLEN  memory address (loads/stores)
ch_pc  in  N_CH*PC_W  pc
ch_instr  in  N_CH*32  instruction
regfile_write_valid  out  1  registered regfile write enable
regfile_write_rd  out  5  write index
regfile_write_data  out  XLEN  write data
commit_valid  out  1  one-cycle commit pulse
commit_pc  out  PC_W  committed pc
commit_instr  out  32  committed instruction
commit_rfwen  out  1  equals regfile_write_valid
commit_skip  out  1  MMIO access, difftest skip
commit_src  out  3  index of the granted channel
retire_count  out  64  committed instruction count

Behaviour:
- Reset: all FIFOs empty; round-robin pointer = 0; every output register and retire_count = 0; ch_ready = all ones from the cycle after reset deasserts. ch_ready = 0 while reset is high.
- Channel order:
  - Channel i field slice is [i*W +: W].
  - Ordering within a channel is FIFO.
  - Ordering across channels is arbitration order. Upstream must not have dependent instructions in flight on two channels at once.
- ch_ready[i] = (count[i] != DEPTH):
  - Derived from registered state only; never depends on ch_valid or a same-cycle pop.
  - A full FIFO rejects a push even in a cycle where it is popped.
- Push: when ch_valid[i] & ch_ready[i], latch all fields into the tail. Pushing while ch_ready = 0 is ignored. The bench checks that no entry is lost or duplicated.
- Eligibility: an entry pushed in cycle t is eligible for grant from t+1 onward. There is no fall-through.
- Grant (cycle t, when ~flush & ~commit_stall): pick one non-empty channel.
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starting at rr_ptr; after a grant, rr_ptr <= (grant+1) mod N_CH. rr_ptr does not change when there is no grant.
  - The granted FIFO pops.
- Output register (loaded at the end of the grant cycle, visible in t+1):
  - commit_valid = 1, plus pc, instr and src of the granted entry.
  - mmio = (is_load | is_store) & (MMIO_BASE <= addr <= MMIO_LIMIT), unsigned compare.
  - commit_skip = mmio.
  - regfile_write_valid = need_to_wb & ~(mmio & is_load).
  - rd and data pass through unchanged; rd = 0 is not gated.
  - With no grant, commit_valid and regfile_write_valid = 0 next cycle and data fields hold their values.
- Latency: push at t, commit_valid at t+2 minimum.
- retire_count increments by 1 in each cycle where a grant occurs. It wraps modulo 2^64.
- commit_stall: no grant and no pop; pushes continue normally.
- Flush (synchronous):
  - All counts go to 0, rr_ptr to 0.
  - Pushes in the same cycle are discarded.
  - No grant is made; commit_valid = 0 next cycle.
  - Flush takes priority over push, pop and stall. retire_count is unaffected.
- Reset has priority over flush. Reset mid-operation discards all entries and clears outputs in the next cycle.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and ordering is preserved.

Test Plan:
- Single push: ch0 at t (pc=0x80000000, rd=5, data=0x1234, need_to_wb=1) -> t+2: commit_valid=1, regfile_write_valid=1, rd=5, data=0x1234, commit_src=0, retire_count=1.
- Fixed-priority contention: N_CH=2, ARB_MODE=0, both channels push 2 entries each in the same cycles -> commits ch0,ch0,ch1,ch1 on consecutive cycles; ch_ready[1] drops to 0 while ch1 is full.
- Round-robin: ARB_MODE=1, N_CH=3, all FIFOs full -> commit_src sequence 0,1,2,0,1,2.
- MMIO load at address 0x30000000 with need_to_wb=1 -> commit_skip=1, regfile_write_valid=0, commit_valid=1. A load at 0x40700001 -> skip=0, write=1.
- Stall then flush: 3 entries buffered, commit_stall held 2 cycles -> no commits. Then flush plus a same-cycle push on ch0 -> no commits afterwards, ch_ready all 1, retire_count unchanged.
- Full boundary: DEPTH=2, ch0 full and popped with ch_valid=1 in the same cycle -> push rejected; the next cycle shows ch_ready[0]=1 and the accepted push commits in order.
